pipdebug_core_responder: RTL and testbench
==========================================

// Module: pipdebug_core_responder
// PURPOSE
// - Core-side (slave) end of the pipdebug channel. Its peer is the debug module, which drives
//   haltreq, resumereq, GPR writes and CSR writes.
// - Halts and resumes the pipeline with a drain handshake and captures DPC.
// - Serves debugger GPR reads and writes, and CSR writes, into the register file and CSR
//   unit, only while the core is halted.
// - Sits between the debug module and the pipeline control / regfile write port.
// PARAMETERS
// - XLEN           64    data width of GPR and CSR values and of the PC
// - GPR_IDX_W      5     GPR index width
// - DRAIN_TIMEOUT  1023  cycles in DRAIN before drain_timeout_o asserts (>=1)
// PORTS
// - clk              in   1          core clock; all state updates on rising edge
// - rst              in   1          synchronous, active-high reset
// - dbg_haltreq_i    in   1          level; debugger requests halt
// - dbg_resumereq_i  in   1          level; acted on at its rising edge
// - dbg_igprwr_i     in   1          level; one GPR write per rising edge
// - dbg_igprindex_i  in   GPR_IDX_W  GPR index, for read and write
// - dbg_igprwdata_i  in   XLEN       GPR write data
// - dbg_igprrdata_o  out  XLEN       registered GPR read data
// - dbg_csrwr_i      in   1          level; one CSR write per rising edge
// - dbg_csrindex_i   in   12         CSR address
// - dbg_csrwdata_i   in   XLEN       CSR write data
// - dbg_halted_o     out  1          core halted; debug accesses are legal
// - dbg_err_o        out  1          sticky: an access arrived while not halted
// - drain_timeout_o  out  1          sticky: drain exceeded DRAIN_TIMEOUT
// - pipe_halt_req_o  out  1          tells the pipeline to stop fetch and drain
// - pipe_quiesced_i  in   1          pipeline empty; no writeback pending
// - pipe_npc_i       in   XLEN       PC of the next instruction to execute
// - pipe_resume_o    out  1          1-cycle pulse; restart fetch at dpc_o
// - dpc_o            out  XLEN       captured debug PC
// - rf_we_o / rf_waddr_o / rf_wdata_o    out  1/GPR_IDX_W/XLEN   regfile debug write port
// - rf_raddr_o       out  GPR_IDX_W  regfile debug read address (= dbg_igprindex_i)
// - rf_rdata_i       in   XLEN       combinational read data for rf_raddr_o
// - csr_we_o / csr_addr_o / csr_wdata_o  out  1/12/XLEN          CSR debug write port
// BEHAVIOUR
// - Reset: FSM=RUN. All outputs 0 (rf_raddr_o follows dbg_igprindex_i).
//   Edge-detect history registers clear to 0. DRAIN counter clears to 0.
// - FSM states RUN, DRAIN, HALTED, RESUME:
//   - RUN -> DRAIN when haltreq=1. resumereq is ignored in RUN.
//   - DRAIN: pipe_halt_req_o=1 and the counter increments.
//     - quiesced=1 -> HALTED. Latch dpc_o<=pipe_npc_i. Clear the counter.
//     - haltreq=0 (debugger abort) -> RUN. pipe_halt_req_o drops.
//     - counter==DRAIN_TIMEOUT -> set drain_timeout_o and stay in DRAIN.
//   - HALTED: pipe_halt_req_o=1 and dbg_halted_o=1. A resumereq rising edge -> RESUME.
//     Resume has priority over a haltreq that is still held.
//   - RESUME (1 cycle): pipe_resume_o=1 and pipe_halt_req_o=0. Clear dbg_err_o and
//     drain_timeout_o. Go to RUN. If haltreq is still 1, re-enter DRAIN on the next cycle.
// - dbg_halted_o is a registered decode of HALTED. It rises 1 cycle after the quiesced
//   sample and falls in the RESUME cycle.
// - GPR read: dbg_igprrdata_o <= rf_rdata_i every cycle while HALTED, giving 1-cycle
//   latency from an index change. The value holds when not HALTED.
// - GPR write: on a rising edge of igprwr while HALTED, rf_we_o pulses 1 cycle, 1 cycle
//   after the edge, with the index and data registered at the edge.
//   - Index 0: the write is dropped; no pulse and no error.
//   - A held level does not re-write.
// - CSR write: same rules as a GPR write (edge, 1 pulse, 1-cycle latency). No address
//   filtering.
// - GPR and CSR edges in the same cycle: both pulses issue together.
// - Write or resume edge outside HALTED (RUN/DRAIN/RESUME): no side effect; set dbg_err_o.
// - Reset mid-drain or mid-write: return to RUN immediately. No rf_we_o or csr_we_o pulse
//   is issued after reset.
// TESTING
// - Halt/resume: haltreq=1, quiesced after 5 cycles, npc=0x8000_0040.
//   -> halted rises at cycle 6 and dpc_o=0x8000_0040.
//   -> resumereq edge gives a 1-cycle pipe_resume_o; halted=0; state RUN.
// - GPR access: halted; write idx 7 data 0xDEAD_BEEF with the level held 4 cycles
//   -> exactly 1 rf_we_o pulse. Write idx 0 -> no pulse.
//   -> Set index 7 with rf_rdata_i=0xDEAD_BEEF -> igprrdata=0xDEAD_BEEF one cycle later.
// - Illegal access: in RUN, pulse igprwr and csrwr.
//   -> no rf_we_o or csr_we_o; dbg_err_o=1 and stays 1 until the RESUME cycle.
// - Drain timeout: DRAIN_TIMEOUT=8, quiesced held 0 -> drain_timeout_o=1 at cycle 8 and
//   the FSM stays in DRAIN. Then drop haltreq -> RUN, pipe_halt_req_o=0.
// - Corner: in HALTED, resumereq edge while haltreq is held -> RESUME, RUN, then DRAIN
//   next cycle. Reset asserted during DRAIN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipdebug_core_responder_if.sv
// pipdebug_core_responder_if: pipdebug channel between the debug module and the core responder
//   master (debug module): drives haltreq, resumereq, GPR index/write, CSR write
//   slave  (core)        : returns GPR read data, halted status, sticky access error
//   haltreq    level, request halt          resumereq  level, acted on at rising edge
//   igprwr     level, one write per edge    igprindex  GPR index for read and write
//   igprwdata  GPR write data               igprrdata  registered GPR read data
//   csrwr      level, one write per edge    csrindex   CSR address
//   csrwdata   CSR write data               halted     core halted, accesses legal
//   err        sticky illegal-access flag
interface pipdebug_core_responder_if #(
    parameter int XLEN      = 64,
    parameter int GPR_IDX_W = 5
);
    logic                 haltreq;
    logic                 resumereq;
    logic                 igprwr;
    logic [GPR_IDX_W-1:0] igprindex;
    logic [XLEN-1:0]      igprwdata;
    logic [XLEN-1:0]      igprrdata;
    logic                 csrwr;
    logic [11:0]          csrindex;
    logic [XLEN-1:0]      csrwdata;
    logic                 halted;
    logic                 err;

    modport master (
        output haltreq, resumereq, igprwr, igprindex, igprwdata, csrwr, csrindex, csrwdata,
        input  igprrdata, halted, err
    );

    modport slave (
        input  haltreq, resumereq, igprwr, igprindex, igprwdata, csrwr, csrindex, csrwdata,
        output igprrdata, halted, err
    );
endinterface

// File: rtl/pipdebug_core_responder.sv
// pipdebug_core_responder: core-side pipdebug responder; halts/resumes the pipeline and serves debugger GPR/CSR access
//   clk, rst                 clock, synchronous active-high reset
//   dbg (slave modport)      debug channel: halt/resume requests, GPR read/write, CSR write, halted, err
//   drain_timeout_o          sticky: pipeline failed to drain within DRAIN_TIMEOUT cycles
//   pipe_halt_req_o          stop fetch and drain (DRAIN and HALTED)
//   pipe_quiesced_i          pipeline empty, no writeback pending
//   pipe_npc_i               PC of next instruction, captured into dpc_o on halt
//   pipe_resume_o            1-cycle pulse: restart fetch at dpc_o
//   dpc_o                    captured debug PC
//   rf_we_o/waddr/wdata      regfile debug write port (1-cycle pulse)
//   rf_raddr_o/rf_rdata_i    regfile debug read port (address follows dbg.igprindex)
//   csr_we_o/addr/wdata      CSR debug write port (1-cycle pulse)
module pipdebug_core_responder #(
    parameter int XLEN          = 64,
    parameter int GPR_IDX_W     = 5,
    parameter int DRAIN_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    pipdebug_core_responder_if.slave dbg,
    output logic                     drain_timeout_o,
    output logic                     pipe_halt_req_o,
    input  logic                     pipe_quiesced_i,
    input  logic [XLEN-1:0]          pipe_npc_i,
    output logic                     pipe_resume_o,
    output logic [XLEN-1:0]          dpc_o,
    output logic                     rf_we_o,
    output logic [GPR_IDX_W-1:0]     rf_waddr_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic [GPR_IDX_W-1:0]     rf_raddr_o,
    input  logic [XLEN-1:0]          rf_rdata_i,
    output logic                     csr_we_o,
    output logic [11:0]              csr_addr_o,
    output logic [XLEN-1:0]          csr_wdata_o
);
    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, RESUME} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 resume_hist_q, gpr_hist_q, csr_hist_q;
    logic                 halt_req_q, halt_req_d;
    logic                 halted_q, halted_d;
    logic                 resume_q, resume_d;
    logic                 err_q, err_d;
    logic                 timeout_q, timeout_d;
    logic [XLEN-1:0]      dpc_q, dpc_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;
    logic                 rf_we_q, rf_we_d;
    logic [GPR_IDX_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 csr_we_q, csr_we_d;
    logic [11:0]          csr_addr_q, csr_addr_d;
    logic [XLEN-1:0]      csr_wdata_q, csr_wdata_d;
    logic                 resume_edge, gpr_edge, csr_edge;
    logic                 halted_now, resuming, tmo_set, gpr_go, csr_go;

    always_comb begin
        resume_edge = dbg.resumereq & ~resume_hist_q;
        gpr_edge    = dbg.igprwr & ~gpr_hist_q;
        csr_edge    = dbg.csrwr & ~csr_hist_q;
        halted_now  = state_q == HALTED;
        state_d     = state_q;
        cnt_d       = '0;
        dpc_d       = dpc_q;
        tmo_set     = 1'b0;
        case (state_q)
            RUN:    state_d = dbg.haltreq ? DRAIN : RUN;
            DRAIN: begin
                // quiesced wins over an abort arriving in the same cycle
                if (pipe_quiesced_i) begin
                    state_d = HALTED;
                    dpc_d   = pipe_npc_i;
                end else if (!dbg.haltreq) begin
                    state_d = RUN;
                end else begin
                    // counter saturates; timeout flags once DRAIN_TIMEOUT cycles have elapsed
                    cnt_d   = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
                    tmo_set = cnt_d == TMO;
                end
            end
            HALTED: state_d = resume_edge ? RESUME : HALTED;
            RESUME: state_d = RUN;
        endcase
        resuming    = state_d == RESUME;
        // edges outside HALTED only flag the error; the RESUME cycle wipes both sticky flags
        err_d       = !resuming && (err_q || (!halted_now && (resume_edge || gpr_edge || csr_edge)));
        timeout_d   = !resuming && (timeout_q || tmo_set);
        // x0 is hardwired, so writes to it are silently dropped
        gpr_go      = halted_now && gpr_edge && (dbg.igprindex != '0);
        csr_go      = halted_now && csr_edge;
        rf_we_d     = gpr_go;
        rf_waddr_d  = gpr_go ? dbg.igprindex : rf_waddr_q;
        rf_wdata_d  = gpr_go ? dbg.igprwdata : rf_wdata_q;
        csr_we_d    = csr_go;
        csr_addr_d  = csr_go ? dbg.csrindex : csr_addr_q;
        csr_wdata_d = csr_go ? dbg.csrwdata : csr_wdata_q;
        rdata_d     = halted_now ? rf_rdata_i : rdata_q;
        // status outputs are registered decodes of the next state
        halt_req_d  = (state_d == DRAIN) || (state_d == HALTED);
        halted_d    = state_d == HALTED;
        resume_d    = resuming;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            resume_hist_q <= 1'b0;
            gpr_hist_q    <= 1'b0;
            csr_hist_q    <= 1'b0;
            halt_req_q    <= 1'b0;
            halted_q      <= 1'b0;
            resume_q      <= 1'b0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            dpc_q         <= '0;
            rdata_q       <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            csr_we_q      <= 1'b0;
            csr_addr_q    <= '0;
            csr_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            resume_hist_q <= dbg.resumereq;
            gpr_hist_q    <= dbg.igprwr;
            csr_hist_q    <= dbg.csrwr;
            halt_req_q    <= halt_req_d;
            halted_q      <= halted_d;
            resume_q      <= resume_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            dpc_q         <= dpc_d;
            rdata_q       <= rdata_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            csr_we_q      <= csr_we_d;
            csr_addr_q    <= csr_addr_d;
            csr_wdata_q   <= csr_wdata_d;
        end
    end

    assign dbg.igprrdata      = rdata_q;
    assign dbg.halted         = halted_q;
    assign dbg.err            = err_q;
    assign drain_timeout_o    = timeout_q;
    assign pipe_halt_req_o    = halt_req_q;
    assign pipe_resume_o      = resume_q;
    assign dpc_o              = dpc_q;
    assign rf_we_o            = rf_we_q;
    assign rf_waddr_o         = rf_waddr_q;
    assign rf_wdata_o         = rf_wdata_q;
    assign rf_raddr_o         = dbg.igprindex;
    assign csr_we_o           = csr_we_q;
    assign csr_addr_o         = csr_addr_q;
    assign csr_wdata_o        = csr_wdata_q;
endmodule

// File: tb/tb_pipdebug_core_responder.sv
// tb_pipdebug_core_responder: directed + randomized bench for pipdebug_core_responder
module tb_pipdebug_core_responder;
    localparam int XLEN      = 64;
    localparam int GPR_IDX_W = 5;
    localparam int TMO       = 8;

    typedef struct packed {
        logic [11:0]     a;
        logic [XLEN-1:0] d;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 drain_timeout, pipe_halt_req, pipe_quiesced, pipe_resume;
    logic [XLEN-1:0]      pipe_npc, dpc;
    logic                 rf_we, csr_we;
    logic [GPR_IDX_W-1:0] rf_waddr, rf_raddr;
    logic [XLEN-1:0]      rf_wdata, rf_rdata, csr_wdata;
    logic [11:0]          csr_addr;
    logic [XLEN-1:0]      rf_mem [32] = '{default: '0};
    logic [XLEN-1:0]      exp_gpr [32] = '{default: '0};
    wr_t                  gpr_q[$];
    wr_t                  csr_q[$];
    int                   passed = 0;
    int                   fails = 0;
    int                   total = 0;

    pipdebug_core_responder_if #(.XLEN(XLEN), .GPR_IDX_W(GPR_IDX_W)) dbg ();

    pipdebug_core_responder #(.XLEN(XLEN), .GPR_IDX_W(GPR_IDX_W), .DRAIN_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .dbg(dbg),
        .drain_timeout_o(drain_timeout), .pipe_halt_req_o(pipe_halt_req),
        .pipe_quiesced_i(pipe_quiesced), .pipe_npc_i(pipe_npc), .pipe_resume_o(pipe_resume),
        .dpc_o(dpc), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
        .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata)
    );

    always #5 clk = ~clk;

    // register file the debug port talks to
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    // every write pulse must match the oldest outstanding expected write
    always @(negedge clk) begin : mon
        wr_t e;
        if (rf_we) begin
            if (gpr_q.size() == 0) chkb("rf_we_spurious", rf_we, 1'b0);
            else begin
                e = gpr_q.pop_front();
                chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
                chk("rf_wdata", rf_wdata, e.d);
            end
        end
        if (csr_we) begin
            if (csr_q.size() == 0) chkb("csr_we_spurious", csr_we, 1'b0);
            else begin
                e = csr_q.pop_front();
                chk("csr_addr", 64'(csr_addr), 64'(e.a));
                chk("csr_wdata", csr_wdata, e.d);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chkb({p, "_halt_req"}, pipe_halt_req, 1'b0);
        chkb({p, "_resume"}, pipe_resume, 1'b0);
        chkb({p, "_timeout"}, drain_timeout, 1'b0);
        chkb({p, "_halted"}, dbg.halted, 1'b0);
        chkb({p, "_err"}, dbg.err, 1'b0);
        chkb({p, "_rf_we"}, rf_we, 1'b0);
        chkb({p, "_csr_we"}, csr_we, 1'b0);
        chk({p, "_dpc"}, dpc, '0);
        chk({p, "_rf_waddr"}, 64'(rf_waddr), '0);
        chk({p, "_rf_wdata"}, rf_wdata, '0);
        chk({p, "_csr_addr"}, 64'(csr_addr), '0);
        chk({p, "_csr_wdata"}, csr_wdata, '0);
        chk({p, "_rdata"}, dbg.igprrdata, '0);
        chk({p, "_raddr"}, 64'(rf_raddr), 64'(dbg.igprindex));
    endtask

    // haltreq raised now, pipeline reports quiesced after k cycles, halted one cycle later
    task automatic do_halt(input int k, input logic [XLEN-1:0] npc);
        dbg.haltreq = 1'b1;
        pipe_npc = npc;
        step();
        chkb("drain_halt_req", pipe_halt_req, 1'b1);
        if (k > 1) step(k - 1);
        chkb("drain_not_halted", dbg.halted, 1'b0);
        pipe_quiesced = 1'b1;
        step();
        chkb("halted_rise", dbg.halted, 1'b1);
        chk("dpc_capture", dpc, npc);
        pipe_npc = {$urandom, $urandom};
        step();
        chk("dpc_hold", dpc, npc);
        chkb("halted_halt_req", pipe_halt_req, 1'b1);
    endtask

    task automatic do_resume();
        dbg.resumereq = 1'b1;
        step();
        chkb("resume_pulse", pipe_resume, 1'b1);
        chkb("resume_unhalted", dbg.halted, 1'b0);
        chkb("resume_halt_req", pipe_halt_req, 1'b0);
        chkb("resume_err_clr", dbg.err, 1'b0);
        chkb("resume_tmo_clr", drain_timeout, 1'b0);
        pipe_quiesced = 1'b0;
        step();
        chkb("resume_one_cycle", pipe_resume, 1'b0);
        chkb("run_halt_req", pipe_halt_req, 1'b0);
        dbg.resumereq = 1'b0;
    endtask

    task automatic gpr_write(input logic [GPR_IDX_W-1:0] idx, input logic [XLEN-1:0] d, input int hold);
        dbg.igprindex = idx;
        dbg.igprwdata = d;
        dbg.igprwr = 1'b1;
        if (idx != 0) begin
            gpr_q.push_back({12'(idx), d});
            exp_gpr[idx] = d;
        end
        step();
        chkb("gpr_we_pulse", rf_we, idx != 0);
        dbg.igprwdata = {$urandom, $urandom};
        for (int h = 1; h < hold; h++) begin
            step();
            chkb("gpr_we_held", rf_we, 1'b0);
        end
        dbg.igprwr = 1'b0;
        step();
        chkb("gpr_we_after", rf_we, 1'b0);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d, input int hold);
        dbg.csrindex = a;
        dbg.csrwdata = d;
        dbg.csrwr = 1'b1;
        csr_q.push_back({a, d});
        step();
        chkb("csr_we_pulse", csr_we, 1'b1);
        dbg.csrwdata = {$urandom, $urandom};
        for (int h = 1; h < hold; h++) begin
            step();
            chkb("csr_we_held", csr_we, 1'b0);
        end
        dbg.csrwr = 1'b0;
        step();
        chkb("csr_we_after", csr_we, 1'b0);
    endtask

    task automatic both_write(input logic [GPR_IDX_W-1:0] idx, input logic [XLEN-1:0] gd,
                              input logic [11:0] a, input logic [XLEN-1:0] cd);
        dbg.igprindex = idx;
        dbg.igprwdata = gd;
        dbg.csrindex = a;
        dbg.csrwdata = cd;
        dbg.igprwr = 1'b1;
        dbg.csrwr = 1'b1;
        gpr_q.push_back({12'(idx), gd});
        csr_q.push_back({a, cd});
        exp_gpr[idx] = gd;
        step();
        chk("both_we", 64'({rf_we, csr_we}), 64'(2'b11));
        dbg.igprwr = 1'b0;
        dbg.csrwr = 1'b0;
        step();
    endtask

    task automatic gpr_read(input logic [GPR_IDX_W-1:0] idx);
        dbg.igprindex = idx;
        step();
        chk("gpr_rdata", dbg.igprrdata, exp_gpr[idx]);
    endtask

    initial begin
        dbg.haltreq = 1'b0;
        dbg.resumereq = 1'b0;
        dbg.igprwr = 1'b0;
        dbg.igprindex = 5'd3;
        dbg.igprwdata = '0;
        dbg.csrwr = 1'b0;
        dbg.csrindex = '0;
        dbg.csrwdata = '0;
        pipe_quiesced = 1'b0;
        pipe_npc = '0;
        step(2);
        chk_reset("reset");
        rst = 1'b0;
        step();

        do_halt(5, 64'h8000_0040);
        gpr_write(5'd7, 64'hDEAD_BEEF, 4);
        gpr_write(5'd0, 64'h1234_5678, 2);
        chkb("idx0_no_err", dbg.err, 1'b0);
        gpr_read(5'd0);
        dbg.igprindex = 5'd7;
        chk("rd_latency_old", dbg.igprrdata, '0);
        step();
        chk("rd_latency_new", dbg.igprrdata, 64'hDEAD_BEEF);
        csr_write(12'h7B0, {$urandom, $urandom}, 3);
        both_write(5'd12, {$urandom, $urandom}, 12'h7B1, {$urandom, $urandom});

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0: gpr_write(5'($urandom), {$urandom, $urandom}, $urandom_range(1, 4));
                1: csr_write(12'($urandom), {$urandom, $urandom}, $urandom_range(1, 4));
                2: gpr_read(5'($urandom));
                default: both_write(5'($urandom_range(1, 31)), {$urandom, $urandom},
                                    12'($urandom), {$urandom, $urandom});
            endcase
        end
        chkb("halted_no_err", dbg.err, 1'b0);
        chk("gpr_sb_drained", 64'(gpr_q.size()), '0);

        gpr_write(5'd7, 64'hCAFE_F00D_0000_0007, 1);
        gpr_read(5'd7);
        dbg.haltreq = 1'b0;
        do_resume();
        dbg.igprindex = 5'd0;
        step(2);
        chk("rdata_hold_run", dbg.igprrdata, 64'hCAFE_F00D_0000_0007);

        dbg.igprindex = 5'd5;
        dbg.igprwr = 1'b1;
        dbg.csrwr = 1'b1;
        step();
        dbg.igprwr = 1'b0;
        dbg.csrwr = 1'b0;
        chkb("err_run_write", dbg.err, 1'b1);
        dbg.resumereq = 1'b1;
        step();
        chkb("resume_ignored_run", pipe_resume, 1'b0);
        chkb("resume_ignored_halt", pipe_halt_req, 1'b0);
        dbg.resumereq = 1'b0;
        step(3);
        chkb("err_sticky_run", dbg.err, 1'b1);
        do_halt($urandom_range(1, TMO), {$urandom, $urandom});
        chkb("err_sticky_halted", dbg.err, 1'b1);
        dbg.haltreq = 1'b0;
        do_resume();

        dbg.haltreq = 1'b1;
        step();
        chkb("tmo_drain", pipe_halt_req, 1'b1);
        step(TMO - 1);
        chkb("tmo_not_yet", drain_timeout, 1'b0);
        step();
        chkb("tmo_set", drain_timeout, 1'b1);
        step(3);
        chkb("tmo_stay_drain", pipe_halt_req, 1'b1);
        chkb("tmo_not_halted", dbg.halted, 1'b0);
        dbg.haltreq = 1'b0;
        step();
        chkb("abort_halt_req", pipe_halt_req, 1'b0);
        chkb("abort_tmo_sticky", drain_timeout, 1'b1);
        step();

        do_halt(3, {$urandom, $urandom});
        do_resume();
        step();
        chkb("redrain_held_halt", pipe_halt_req, 1'b1);
        dbg.igprwr = 1'b1;
        step();
        dbg.igprwr = 1'b0;
        chkb("err_drain_write", dbg.err, 1'b1);
        rst = 1'b1;
        dbg.haltreq = 1'b0;
        step();
        chk_reset("rst_drain");
        rst = 1'b0;
        step();

        do_halt(2, {$urandom, $urandom});
        dbg.haltreq = 1'b0;
        dbg.igprindex = 5'd9;
        dbg.igprwdata = {$urandom, $urandom};
        dbg.igprwr = 1'b1;
        rst = 1'b1;
        step();
        chkb("rst_write_no_we", rf_we, 1'b0);
        chkb("rst_write_halted", dbg.halted, 1'b0);
        rst = 1'b0;
        dbg.igprwr = 1'b0;
        pipe_quiesced = 1'b0;
        step();
        chkb("rst_write_no_we_after", rf_we, 1'b0);
        step(2);

        chk("gpr_sb_empty", 64'(gpr_q.size()), '0);
        chk("csr_sb_empty", 64'(csr_q.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
